// File: rtl/dmem_arb_pkg.sv
// Shared types and funct3 encodings for the data-memory arbiter.
package dmem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {OWN_M0, OWN_M1} owner_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of an RV32 load/store: width encoding and natural alignment.
module dmem_access_check
    import dmem_arb_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        if (!(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) begin
            err = 1'b1;
        end else if (funct3[1:0] == 2'b01 && addr_lo[0]) begin
            err = 1'b1;
        end else if (funct3[1:0] == 2'b10 && addr_lo != 2'b00) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory/MMIO port with a one-cycle response path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_write,
    input  logic [2:0]  m0_req_funct3,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_write,
    input  logic [2:0]  m1_req_funct3,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic [2:0]  mem_funct3,
    output logic        mem_wren,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    req_t   req0, req1, sel;
    logic   err0, err1, sel_err;
    logic   grant0, grant1, grant_any;
    owner_t last_grant;
    logic [7:0] starve_cnt;
    logic   rsp_pend, rsp_err, rsp_write;
    owner_t rsp_owner;

    assign req0 = '{write: m0_req_write, funct3: m0_req_funct3, addr: m0_req_addr, wdata: m0_req_wdata};
    assign req1 = '{write: m1_req_write, funct3: m1_req_funct3, addr: m1_req_addr, wdata: m1_req_wdata};

    dmem_access_check u_chk0 (.funct3(m0_req_funct3), .addr_lo(m0_req_addr[1:0]), .err(err0));
    dmem_access_check u_chk1 (.funct3(m1_req_funct3), .addr_lo(m1_req_addr[1:0]), .err(err1));

    // Grants are gated by reset so ready stays low while the block is held in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset) begin
            if (ARB_MODE == 0) begin
                if (m0_req_valid && m1_req_valid) begin
                    if (last_grant == OWN_M1) grant0 = 1'b1;
                    else                      grant1 = 1'b1;
                end else begin
                    grant0 = m0_req_valid;
                    grant1 = m1_req_valid;
                end
            end else begin
                if (m1_req_valid && (!m0_req_valid || starve_cnt == LIMIT)) grant1 = 1'b1;
                else                                                        grant0 = m0_req_valid;
            end
        end
    end

    assign grant_any    = grant0 | grant1;
    assign sel          = grant1 ? req1 : req0;
    assign sel_err      = grant1 ? err1 : err0;
    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;

    always_comb begin
        mem_funct3  = '0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        if (grant_any) begin
            mem_funct3 = sel.funct3;
            if (!sel_err) begin
                mem_wren    = sel.write;
                mem_address = sel.addr;
                mem_data_in = sel.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_M1;
            starve_cnt <= '0;
            rsp_pend   <= 1'b0;
            rsp_owner  <= OWN_M0;
            rsp_err    <= 1'b0;
            rsp_write  <= 1'b0;
        end else begin
            if (grant_any) last_grant <= grant1 ? OWN_M1 : OWN_M0;
            if (m1_req_valid && !grant1)
                starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 8'd1;
            else
                starve_cnt <= '0;
            rsp_pend  <= grant_any;
            rsp_owner <= grant1 ? OWN_M1 : OWN_M0;
            rsp_err   <= grant_any & sel_err;
            rsp_write <= grant_any & sel.write;
        end
    end

    always_comb begin
        m0_rsp_valid = rsp_pend && rsp_owner == OWN_M0;
        m1_rsp_valid = rsp_pend && rsp_owner == OWN_M1;
        m0_rsp_err   = m0_rsp_valid & rsp_err;
        m1_rsp_err   = m1_rsp_valid & rsp_err;
        m0_rsp_rdata = (m0_rsp_valid && !rsp_err && !rsp_write) ? mem_data_out : '0;
        m1_rsp_rdata = (m1_rsp_valid && !rsp_err && !rsp_write) ? mem_data_out : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances share stimulus and a reference model.
module tb_dmem_arbiter;

    typedef struct {
        logic        v;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
    } rq_t;

    typedef struct {
        rq_t         r0;
        rq_t         r1;
        logic [31:0] md;
        int          g_rr;
        int          g_fp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_req_valid, m0_req_write, m1_req_valid, m1_req_write;
    logic [2:0]  m0_req_funct3, m1_req_funct3;
    logic [31:0] m0_req_addr, m0_req_wdata, m1_req_addr, m1_req_wdata, mem_data_out;

    logic [1:0] o_m0_ready, o_m1_ready, o_m0_rsp_valid, o_m1_rsp_valid;
    logic [1:0] o_m0_rsp_err, o_m1_rsp_err, o_mem_wren;
    logic [1:0][31:0] o_m0_rdata, o_m1_rdata, o_mem_address, o_mem_data_in;
    logic [1:0][2:0]  o_mem_funct3;

    int total = 0;
    int bad = 0;

    int last_g [2];
    int starve [2];
    bit pend   [2];
    int powner [2];
    bit perr   [2];
    bit pwrite [2];
    int lim    [2] = '{8, 3};

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        dmem_arbiter #(.ARB_MODE(g), .STARVE_LIMIT(g == 0 ? 8 : 3)) u_dut (
            .clk(clk), .reset(reset),
            .m0_req_valid(m0_req_valid), .m0_req_ready(o_m0_ready[g]), .m0_req_write(m0_req_write),
            .m0_req_funct3(m0_req_funct3), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
            .m0_rsp_valid(o_m0_rsp_valid[g]), .m0_rsp_rdata(o_m0_rdata[g]), .m0_rsp_err(o_m0_rsp_err[g]),
            .m1_req_valid(m1_req_valid), .m1_req_ready(o_m1_ready[g]), .m1_req_write(m1_req_write),
            .m1_req_funct3(m1_req_funct3), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
            .m1_rsp_valid(o_m1_rsp_valid[g]), .m1_rsp_rdata(o_m1_rdata[g]), .m1_rsp_err(o_m1_rsp_err[g]),
            .mem_funct3(o_mem_funct3[g]), .mem_wren(o_mem_wren[g]), .mem_address(o_mem_address[g]),
            .mem_data_in(o_mem_data_in[g]), .mem_data_out(mem_data_out)
        );
    end

    function automatic rq_t rq(logic v, logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        rq_t r;
        r.v = v; r.w = w; r.f3 = f3; r.a = a; r.d = d;
        return r;
    endfunction

    // An access is legal only for the five defined widths, and only when the address is a multiple of its size.
    function automatic bit ill(logic [2:0] f3, logic [31:0] a);
        int sz;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    function automatic rq_t cur(int k);
        if (k == 1) return rq(m0_req_valid, m0_req_write, m0_req_funct3, m0_req_addr, m0_req_wdata);
        return rq(m1_req_valid, m1_req_write, m1_req_funct3, m1_req_addr, m1_req_wdata);
    endfunction

    // Returns 0 for no grant, 1 for m0, 2 for m1.
    function automatic int exp_grant(int m);
        if (!reset) return 0;
        if (m == 0) begin
            if (m0_req_valid && m1_req_valid) return (last_g[0] == 2) ? 1 : 2;
            if (m0_req_valid) return 1;
            if (m1_req_valid) return 2;
            return 0;
        end
        if (m1_req_valid && (!m0_req_valid || starve[1] == lim[1])) return 2;
        if (m0_req_valid) return 1;
        return 0;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(rq_t r0, rq_t r1, logic [31:0] md);
        m0_req_valid = r0.v; m0_req_write = r0.w; m0_req_funct3 = r0.f3; m0_req_addr = r0.a; m0_req_wdata = r0.d;
        m1_req_valid = r1.v; m1_req_write = r1.w; m1_req_funct3 = r1.f3; m1_req_addr = r1.a; m1_req_wdata = r1.d;
        mem_data_out = md;
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int g;
            rq_t s;
            logic [67:0] em;
            logic [33:0] er0, er1;
            bit ev;
            g = exp_grant(m);
            chk($sformatf("ready mode%0d", m), 128'({o_m1_ready[m], o_m0_ready[m]}), 128'({g == 2, g == 1}));
            em = '0;
            if (g != 0) begin
                s = cur(g);
                em[67:65] = s.f3;
                if (!ill(s.f3, s.a)) begin
                    em[64] = s.w;
                    em[63:32] = s.a;
                    em[31:0] = s.d;
                end
            end
            chk($sformatf("mem port mode%0d", m),
                128'({o_mem_funct3[m], o_mem_wren[m], o_mem_address[m], o_mem_data_in[m]}), 128'(em));
            ev = pend[m] && powner[m] == 1;
            er0 = {ev, ev && perr[m], (ev && !perr[m] && !pwrite[m]) ? mem_data_out : 32'h0};
            ev = pend[m] && powner[m] == 2;
            er1 = {ev, ev && perr[m], (ev && !perr[m] && !pwrite[m]) ? mem_data_out : 32'h0};
            chk($sformatf("m0 rsp mode%0d", m), 128'({o_m0_rsp_valid[m], o_m0_rsp_err[m], o_m0_rdata[m]}), 128'(er0));
            chk($sformatf("m1 rsp mode%0d", m), 128'({o_m1_rsp_valid[m], o_m1_rsp_err[m], o_m1_rdata[m]}), 128'(er1));
        end
    endtask

    // Advances the model across the coming posedge using the inputs currently applied.
    task automatic model_tick();
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                last_g[m] = 2; starve[m] = 0; pend[m] = 1'b0; powner[m] = 0; perr[m] = 1'b0; pwrite[m] = 1'b0;
            end else begin
                int g;
                rq_t s;
                g = exp_grant(m);
                if (g != 0) last_g[m] = g;
                if (m1_req_valid && g != 2) starve[m] = (starve[m] + 1 > lim[m]) ? lim[m] : starve[m] + 1;
                else starve[m] = 0;
                pend[m] = (g != 0);
                powner[m] = g;
                s = cur(g == 0 ? 1 : g);
                perr[m] = (g != 0) && ill(s.f3, s.a);
                pwrite[m] = (g != 0) && s.w;
            end
        end
    endtask

    task automatic run_cycle(rq_t r0, rq_t r1, logic [31:0] md);
        drive(r0, r1, md);
        @(negedge clk);
        check_all();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(rq(0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0), 32'h0);
        #2;
        check_all();
        model_tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        rq_t  idle;
        rq_t  a0, a1;
        int   rr_seq [5] = '{1, 2, 1, 2, 1};
        int   fp_seq [5] = '{1, 1, 1, 2, 1};

        idle = rq(0, 0, 0, 0, 0);
        tbl[0]  = '{rq(1, 0, 3'd2, 32'h100, 0), idle, 32'h0, 1, 1};
        tbl[1]  = '{idle, idle, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{rq(1, 0, 3'd0, 32'h200, 0), rq(1, 0, 3'd2, 32'h300, 0), 32'h11111111, 2, 1};
        tbl[3]  = '{rq(1, 1, 3'd1, 32'h202, 32'hAAAA), rq(1, 0, 3'd5, 32'h302, 0), 32'h22222222, 1, 1};
        tbl[4]  = '{rq(1, 0, 3'd4, 32'h203, 0), rq(1, 1, 3'd2, 32'h304, 32'h12345678), 32'h33333333, 2, 1};
        tbl[5]  = '{rq(1, 0, 3'd2, 32'h208, 0), rq(1, 0, 3'd1, 32'h306, 0), 32'h44444444, 1, 2};
        tbl[6]  = '{rq(1, 1, 3'd0, 32'h209, 32'h5A), rq(1, 0, 3'd2, 32'h308, 0), 32'h66666666, 2, 1};
        tbl[7]  = '{idle, rq(1, 0, 3'd2, 32'h400, 0), 32'h77777777, 2, 2};
        tbl[8]  = '{idle, rq(1, 1, 3'd1, 32'h103, 32'hBEEF), 32'h88888888, 2, 2};
        tbl[9]  = '{rq(1, 0, 3'd3, 32'h100, 0), idle, 32'h99999999, 1, 1};
        tbl[10] = '{idle, idle, 32'h55555555, 0, 0};

        reset = 1'b1;
        drive(idle, idle, 32'h0);
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].md);
            @(negedge clk);
            check_all();
            chk($sformatf("tbl%0d grant rr", i), 128'({o_m1_ready[0], o_m0_ready[0]}),
                128'({tbl[i].g_rr == 2, tbl[i].g_rr == 1}));
            chk($sformatf("tbl%0d grant fp", i), 128'({o_m1_ready[1], o_m0_ready[1]}),
                128'({tbl[i].g_fp == 2, tbl[i].g_fp == 1}));
            if (i == 1) chk("single load rdata", 128'(o_m0_rdata[0]), 128'(32'hDEADBEEF));
            if (i == 8) chk("misaligned store wren", 128'(o_mem_wren), 128'(2'b00));
            if (i == 9) chk("misaligned store err", 128'({o_m1_rsp_valid, o_m1_rsp_err}), 128'(4'b1111));
            if (i == 10) chk("illegal f3 rsp", 128'({o_m0_rsp_err, o_m0_rdata}), 128'({2'b11, 64'h0}));
            model_tick();
            @(posedge clk);
            #1;
        end

        do_reset();
        a0 = rq(1, 0, 3'd2, 32'h10, 0);
        a1 = rq(1, 0, 3'd2, 32'h20, 0);
        for (int i = 0; i < 5; i++) begin
            drive(a0, a1, 32'h0BAD0000 + 32'(i));
            @(negedge clk);
            check_all();
            chk($sformatf("rr seq%0d", i), 128'({o_m1_ready[0], o_m0_ready[0]}), 128'({rr_seq[i] == 2, rr_seq[i] == 1}));
            chk($sformatf("starve seq%0d", i), 128'({o_m1_ready[1], o_m0_ready[1]}), 128'({fp_seq[i] == 2, fp_seq[i] == 1}));
            model_tick();
            @(posedge clk);
            #1;
        end

        drive(rq(1, 0, 3'd2, 32'h100, 0), idle, 32'h0);
        @(negedge clk);
        check_all();
        model_tick();
        reset = 1'b0;
        model_tick();
        #1;
        check_all();
        chk("reset hold outputs", 128'({o_m0_ready, o_m1_ready, o_m0_rsp_valid, o_m1_rsp_valid, o_mem_wren}), 128'(0));
        @(posedge clk);
        #1;
        check_all();
        model_tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(idle, idle, 32'hCAFEF00D);
            @(negedge clk);
            check_all();
            chk($sformatf("post reset rsp%0d", i), 128'({o_m0_rsp_valid, o_m1_rsp_valid}), 128'(0));
            model_tick();
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 400; i++) begin
            rq_t r0, r1;
            r0 = rq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            r1 = rq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            run_cycle(r0, r1, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/MMIO port between two requesters: m0 (CPU load/store unit) and m1 (debug/DMA loader).
- Accepts at most one request per cycle using valid/ready handshakes and drives the memory-side port combinationally from the granted request.
- Routes the 1-cycle-latency read data back to the owner of that request.
- Rejects misaligned or illegal-width accesses without touching memory.

Parameters:
- ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with m0 high.
- STARVE_LIMIT, default 8: in ARB_MODE 1, the number of consecutive cycles m1 may be denied before it is force-granted. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state on posedge
- reset  input  1  asynchronous, active-low reset
- m0_req_valid  input  1  m0 request present
- m0_req_ready  output  1  m0 request accepted this cycle
- m0_req_write  input  1  1 = store, 0 = load
- m0_req_funct3  input  3  RV32 load/store funct3 (width and sign)
- m0_req_addr  input  32  byte address
- m0_req_wdata  input  32  store data, right-aligned
- m0_rsp_valid  output  1  one-cycle response pulse
- m0_rsp_rdata  output  32  load data, valid with rsp_valid
- m0_rsp_err  output  1  access rejected, valid with rsp_valid
- m1_*  same set as m0_*, for requester m1
- mem_funct3  output  3  to memory port
- mem_wren  output  1  to memory port
- mem_address  output  32  to memory port
- mem_data_in  output  32  to memory port
- mem_data_out  input  32  from memory port; valid the cycle after the address is presented

Behaviour:
Grant
- Combinational in the request cycle; the memory samples at the following posedge.
- mX_req_ready = grant to X. Ready depends on both valids, so requesters must not derive valid from ready.
- Only one requester is granted per cycle.
- mem_* outputs carry the granted request's fields when a grant is made; otherwise all mem_* outputs are 0.

Round-robin (ARB_MODE 0)
- Register last_grant, reset value m1, so m0 wins the first contention.
- Under contention, the requester that is not last_grant wins.
- last_grant updates on every grant.

Fixed priority (ARB_MODE 1)
- m0 wins unless starve_cnt == STARVE_LIMIT, in which case m1 is granted and starve_cnt clears.
- starve_cnt (8 bits) increments on each cycle m1_req_valid=1 and is not granted; it clears when m1 is granted or m1_req_valid=0.
- starve_cnt saturates at STARVE_LIMIT.

Legality check
- err when funct3 is in {011, 110, 111}; or halfword (funct3[1:0]=01) with addr[0]=1; or word (funct3[1:0]=10) with addr[1:0]!=0.
- An erroring request is still granted (ready=1), but mem_wren=0 and mem_address/mem_data_in are driven 0.

Response pipeline
- Registers: rsp_pend, rsp_owner, rsp_err, all reset to 0.
- Every accepted request, load or store, produces exactly one response pulse on its owner's rsp_valid in the next cycle.
- Responses have no backpressure.
- rsp_rdata = mem_data_out for a non-error load; 0 for stores and errors.
- rsp_err = registered err bit.
- The non-owner's rsp_valid, rsp_rdata and rsp_err are 0.
- Back-to-back: a new grant in the response cycle is legal, giving full throughput of 1 request per cycle.

Reset
- While reset=0: all ready, rsp_valid, rsp_err and mem_wren are 0; starve_cnt = 0; last_grant = m1.
- Reset asserted mid-operation drops any pending response; no rsp_valid appears after release for a pre-reset request.

Decomposition:
- dmem_arb_pkg holds:
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101)
  - typedef enum logic {OWN_M0, OWN_M1} owner_t
  - typedef struct req_t {write, funct3, addr, wdata}
- One sub-module, dmem_access_check: purely combinational funct3/alignment legality, instantiated once per requester.

Test Plan:
- Single load: m0 valid, load, funct3=010, addr=0x100, mem_data_out=0xDEADBEEF next cycle -> m0_req_ready=1 same cycle; m0_rsp_valid=1 next cycle with rdata 0xDEADBEEF, err 0; m1_rsp_valid stays 0.
- Round-robin contention: both valid for 4 cycles, ARB_MODE 0 -> grants m0, m1, m0, m1; each response goes to the correct owner one cycle later.
- Starvation: ARB_MODE 1, STARVE_LIMIT=3, both valid continuously -> m0 granted 3 cycles, m1 granted on the 4th, then m0 again.
- Misaligned store: m1 store, funct3=001, addr=0x103 -> ready=1, mem_wren=0, m1_rsp_err=1 next cycle; memory contents unchanged.
- Illegal funct3=011 load on m0 -> m0_rsp_err=1, m0_rsp_rdata=0.
- Reset mid-read: grant a load, pulse reset low before the next edge -> no rsp_valid after release; all outputs 0 while reset is low.
